// File: rtl/pwm_deadtime_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : pwm_deadtime_gen
// Purpose  : Complementary gate-pair generator for one inverter leg. Compares
//            a shadow-buffered duty level against an external 8-bit triangle
//            carrier, then inserts a programmable both-off interval between
//            the high-side and low-side switches.
// Ports    : clk      - system clock
//            rst_n    - asynchronous active-low reset
//            en       - leg enable; low forces both switches off
//            carrier  - triangle carrier, 0..2^CW-1
//            duty     - compare level, captured only on update events
//            deadtime - both-off interval in clk cycles, captured on updates
//            pwm_hi   - high-side gate command (registered)
//            pwm_lo   - low-side gate command (registered)
//            update   - one-cycle pulse when the shadow registers load
// Options  : PWM_DOUBLE_UPDATE_EN - also load shadows at the carrier peak
// Revision : 1.0 - initial release
// ============================================================================
module pwm_deadtime_gen #(
  parameter int CW  = 8,
  parameter int DTW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [CW-1:0]  carrier,
  input  logic [CW-1:0]  duty,
  input  logic [DTW-1:0] deadtime,
  output logic           pwm_hi,
  output logic           pwm_lo,
  output logic           update
);

  localparam logic [2:0] S_OFF   = 3'd0;
  localparam logic [2:0] S_LO    = 3'd1;
  localparam logic [2:0] S_DT_HI = 3'd2;
  localparam logic [2:0] S_HI    = 3'd3;
  localparam logic [2:0] S_DT_LO = 3'd4;

  localparam logic [CW-1:0]  CARRIER_MAX = '1;
  localparam logic [DTW-1:0] DT_ONE      = DTW'(1);

  logic [CW-1:0]  carrier_q;
  logic [CW-1:0]  duty_sh_q;
  logic [DTW-1:0] dt_sh_q;
  logic [2:0]     state_q, state_d;
  logic [DTW-1:0] dt_cnt_q, dt_cnt_d;
  logic           pwm_hi_q, pwm_lo_q, update_q;

  logic valley_evt;
  logic upd_evt;
  logic cmp_ref;

  // Edge-detected against the previous carrier sample so a carrier that
  // dwells at the valley produces a single event.
  assign valley_evt = (carrier == '0) && (carrier_q != '0);

`ifdef PWM_DOUBLE_UPDATE_EN
  logic peak_evt;
  assign peak_evt = (carrier == CARRIER_MAX) && (carrier_q != CARRIER_MAX);
  assign upd_evt  = valley_evt | peak_evt;
`else
  assign upd_evt  = valley_evt;
`endif

  assign cmp_ref = (carrier < duty_sh_q);

  // Shadow registers and carrier history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carrier_q <= '0;
      duty_sh_q <= '0;
      dt_sh_q   <= '0;
      update_q  <= 1'b0;
    end else begin
      carrier_q <= carrier;
      update_q  <= upd_evt;
      if (upd_evt) begin
        duty_sh_q <= duty;
        dt_sh_q   <= deadtime;
      end
    end
  end

  // Gate sequencing. Dead-time states abort straight back to the previous
  // conducting side when the reference reverts before the interval ends;
  // that side never switched off from the gate's point of view of the
  // opposite device, so no extra both-off time is needed.
  always_comb begin
    state_d  = state_q;
    dt_cnt_d = dt_cnt_q;
    if (!en) begin
      state_d = S_OFF;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d  = cmp_ref ? S_DT_HI : S_DT_LO;
          dt_cnt_d = dt_sh_q;
        end
        S_LO: begin
          if (cmp_ref) begin
            state_d  = S_DT_HI;
            dt_cnt_d = dt_sh_q;
          end
        end
        S_HI: begin
          if (!cmp_ref) begin
            state_d  = S_DT_LO;
            dt_cnt_d = dt_sh_q;
          end
        end
        S_DT_HI: begin
          if (!cmp_ref) begin
            state_d = S_LO;
          end else if (dt_cnt_q <= DT_ONE) begin
            state_d = S_HI;
          end else begin
            dt_cnt_d = dt_cnt_q - DT_ONE;
          end
        end
        S_DT_LO: begin
          if (cmp_ref) begin
            state_d = S_HI;
          end else if (dt_cnt_q <= DT_ONE) begin
            state_d = S_LO;
          end else begin
            dt_cnt_d = dt_cnt_q - DT_ONE;
          end
        end
        default: begin
          state_d = S_OFF;
        end
      endcase
    end
  end

  // Outputs decode the next state so they line up with the registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_OFF;
      dt_cnt_q <= '0;
      pwm_hi_q <= 1'b0;
      pwm_lo_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dt_cnt_q <= dt_cnt_d;
      pwm_hi_q <= (state_d == S_HI);
      pwm_lo_q <= (state_d == S_LO);
    end
  end

  assign pwm_hi = pwm_hi_q;
  assign pwm_lo = pwm_lo_q;
  assign update = update_q;

endmodule
`default_nettype wire
